clk_divider_multi: RTL and testbench

Parametrised multi-channel clock/tick generator: the successor to the fixed two-output 50 Hz/10 Hz divider. It derives NUM_CH independent square-wave enables from the single system clock. Each channel has a run-time programmable divisor, glitch-free divisor updates, per-channel enable, a global phase-align clear, and a one-cycle tick strobe. It feeds game-logic timing (input debounce, animation, display refresh) in place of hard-coded counters.

---
 rtl/clk_divider_multi.sv | 68 ++++++
 tb/tb_clk_divider_multi.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_divider_multi.sv
// Multi-channel programmable clock/tick generator: each channel divides clk by 2*(D+1)
// and strobes tick on every output transition, with shadowed, glitch-free divisor updates.
module clk_divider_multi #(
  parameter int                        NUM_CH   = 2,
  parameter int                        CNT_W    = 26,
  parameter logic [NUM_CH*CNT_W-1:0]   DIV_INIT = {26'd5_000_000, 26'd1_000_000},
  localparam int                       CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync_clr,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  // Config port handshake: cfg_we is a single-cycle strobe with no ready; every write
  // is accepted on the edge it is sampled. Out-of-range cfg_ch matches no channel.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] act_div;
    logic [CNT_W-1:0] shd_div;
    logic [CNT_W-1:0] nxt_div;
    logic             clk_q;
    logic             tick_q;
    logic             wr;

    assign wr      = cfg_we && (int'(cfg_ch) == i);
    // A write in the same cycle as a reload bypasses the shadow so it is never lost.
    assign nxt_div = wr ? cfg_div : shd_div;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt     <= '0;
        act_div <= DIV_INIT[i*CNT_W +: CNT_W];
        shd_div <= DIV_INIT[i*CNT_W +: CNT_W];
        clk_q   <= 1'b0;
        tick_q  <= 1'b0;
      end else begin
        if (wr) begin
          shd_div <= cfg_div;
        end
        if (sync_clr || !en[i]) begin
          cnt     <= '0;
          clk_q   <= 1'b0;
          tick_q  <= 1'b0;
          act_div <= nxt_div;
        end else if (cnt != act_div) begin
          cnt     <= cnt + CNT_W'(1);
          tick_q  <= 1'b0;
        end else begin
          // Divisor only changes here, with cnt returning to 0, so cnt never passes act_div.
          cnt     <= '0;
          clk_q   <= ~clk_q;
          tick_q  <= 1'b1;
          act_div <= nxt_div;
        end
      end
    end

    assign clk_out[i] = clk_q;
    assign tick[i]    = tick_q;
  end

endmodule

// File: tb/tb_clk_divider_multi.sv
// Bench for clk_divider_multi with CNT_W=8, DIV_INIT={9,3}: expected {clk_out,tick} per edge
// comes from the closed-form square-wave formula for each channel segment.
module tb_clk_divider_multi;
  localparam int NUM_CH = 2;
  localparam int CNT_W  = 8;
  localparam int W      = 4;
  localparam logic [NUM_CH*CNT_W-1:0] DIV_INIT = {8'd9, 8'd3};

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NUM_CH-1:0] en = '0;
  logic              sync_clr = 1'b0;
  logic              cfg_we = 1'b0;
  logic [0:0]        cfg_ch = '0;
  logic [CNT_W-1:0]  cfg_div = '0;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  clk_divider_multi #(
    .NUM_CH  (NUM_CH),
    .CNT_W   (CNT_W),
    .DIV_INIT(DIV_INIT)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .sync_clr(sync_clr),
    .cfg_we  (cfg_we),
    .cfg_ch  (cfg_ch),
    .cfg_div (cfg_div),
    .clk_out (clk_out),
    .tick    (tick)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  // {clk,tick} of a channel k edges after a fresh start (cnt=0) at level l0 with divisor d.
  function automatic logic [1:0] wave(input int d, input int k, input logic l0);
    logic [1:0] r;
    if (k <= 0) r = {l0, 1'b0};
    else r = {l0 ^ (((k / (d + 1)) % 2) == 1), (k % (d + 1)) == 0};
    return r;
  endfunction

  function automatic logic [W-1:0] pack2(input logic [1:0] c0, input logic [1:0] c1);
    return {c1[1], c0[1], c1[0], c0[0]};
  endfunction

  // ---------------- driver tasks ----------------
  // One edge with both channels disabled, optionally writing a divisor (immediate load).
  task automatic idle_write(input bit do_wr, input int ch, input int d);
    en      = '0;
    cfg_we  = do_wr;
    cfg_ch  = 1'(ch);
    cfg_div = CNT_W'(d);
    @(posedge clk); #1;
    cfg_we  = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [W-1:0] e, got;
    rst_n = 1'b0;
    en    = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({clk_out, tick} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_hold got=%b exp=0000", {clk_out, tick});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({clk_out, tick} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_idle got=%b exp=0000", {clk_out, tick});
    end
    en = 2'b11;
    for (int k = 1; k <= 44; k++) begin
      exp_q.push_back(pack2(wave(3, k, 1'b0), wave(9, k, 1'b0)));
      @(posedge clk); #1;
      got = {clk_out, tick};
      e   = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL default_run k=%0d got=%b exp=%b", k, got, e);
      end
    end
  endtask

  task automatic test_glitch_free();
    logic [W-1:0] e, got;
    logic [1:0] c0;
    // Write D=7 while cnt=1: current half-period still ends at edge 4.
    idle_write(1'b1, 0, 3);
    en      = 2'b11;
    cfg_ch  = 1'b0;
    cfg_div = 8'd7;
    for (int k = 1; k <= 30; k++) begin
      cfg_we = (k == 2);
      c0 = (k <= 4) ? wave(3, k, 1'b0) : wave(7, k - 4, wave(3, 4, 1'b0) >> 1);
      exp_q.push_back(pack2(c0, wave(9, k, 1'b0)));
      @(posedge clk); #1;
      got = {clk_out, tick};
      e   = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL glitch_mid k=%0d got=%b exp=%b", k, got, e);
      end
    end
    cfg_we = 1'b0;
    // Write D=7 on the wrap edge 8: the very next half-period is already 8 long.
    idle_write(1'b1, 0, 3);
    en      = 2'b11;
    cfg_div = 8'd7;
    for (int k = 1; k <= 30; k++) begin
      cfg_we = (k == 8);
      c0 = (k <= 8) ? wave(3, k, 1'b0) : wave(7, k - 8, wave(3, 8, 1'b0) >> 1);
      exp_q.push_back(pack2(c0, wave(9, k, 1'b0)));
      @(posedge clk); #1;
      got = {clk_out, tick};
      e   = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL glitch_wrap k=%0d got=%b exp=%b", k, got, e);
      end
    end
    cfg_we = 1'b0;
  endtask

  task automatic test_disable();
    logic [W-1:0] e, got;
    logic [1:0] c0;
    idle_write(1'b1, 0, 3);
    for (int k = 1; k <= 40; k++) begin
      en = {1'b1, !(k >= 6 && k <= 9)};
      if (k < 6)       c0 = wave(3, k, 1'b0);
      else if (k <= 9) c0 = 2'b00;
      else             c0 = wave(3, k - 9, 1'b0);
      exp_q.push_back(pack2(c0, wave(9, k, 1'b0)));
      @(posedge clk); #1;
      got = {clk_out, tick};
      e   = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL disable k=%0d got=%b exp=%b", k, got, e);
      end
    end
  endtask

  task automatic test_sync_clr();
    logic [W-1:0] e, got;
    idle_write(1'b1, 0, 3);
    en      = 2'b11;
    cfg_ch  = 1'b1;
    cfg_div = 8'd5;
    for (int k = 1; k <= 36; k++) begin
      // sync_clr and a ch1 write share edge 8; ch1 restarts directly with D=5.
      sync_clr = (k == 8);
      cfg_we   = (k == 8);
      if (k < 8) exp_q.push_back(pack2(wave(3, k, 1'b0), wave(9, k, 1'b0)));
      else       exp_q.push_back(pack2(wave(3, k - 8, 1'b0), wave(5, k - 8, 1'b0)));
      @(posedge clk); #1;
      got = {clk_out, tick};
      e   = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL sync_clr k=%0d got=%b exp=%b", k, got, e);
      end
      if (k == 32) begin
        n_checks++;
        if (tick !== 2'b11 || clk_out !== 2'b00) begin
          n_fail++;
          $display("FAIL lcm_realign got clk=%b tick=%b exp clk=00 tick=11", clk_out, tick);
        end
      end
    end
    sync_clr = 1'b0;
    cfg_we   = 1'b0;
  endtask

  task automatic test_div_zero();
    logic [W-1:0] e, got;
    logic [1:0] c0;
    idle_write(1'b1, 0, 0);
    en      = 2'b11;
    cfg_ch  = 1'b0;
    cfg_div = 8'd2;
    for (int k = 1; k <= 30; k++) begin
      cfg_we = (k == 5);
      c0 = (k <= 5) ? wave(0, k, 1'b0) : wave(2, k - 5, wave(0, 5, 1'b0) >> 1);
      exp_q.push_back(pack2(c0, wave(5, k, 1'b0)));
      @(posedge clk); #1;
      got = {clk_out, tick};
      e   = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL div_zero k=%0d got=%b exp=%b", k, got, e);
      end
    end
    cfg_we = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [W-1:0] e, got;
    idle_write(1'b0, 0, 0);
    en = 2'b11;
    for (int k = 1; k <= 6; k++) begin
      exp_q.push_back(pack2(wave(2, k, 1'b0), wave(5, k, 1'b0)));
      @(posedge clk); #1;
      got = {clk_out, tick};
      e   = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL pre_reset k=%0d got=%b exp=%b", k, got, e);
      end
    end
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({clk_out, tick} !== 4'b0) begin
      n_fail++;
      $display("FAIL async_assert got=%b exp=0000", {clk_out, tick});
    end
    @(posedge clk); #1;
    n_checks++;
    if ({clk_out, tick} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_edge got=%b exp=0000", {clk_out, tick});
    end
    rst_n = 1'b1;
    // Divisors are back to DIV_INIT {9,3} after reset.
    for (int k = 1; k <= 24; k++) begin
      exp_q.push_back(pack2(wave(3, k, 1'b0), wave(9, k, 1'b0)));
      @(posedge clk); #1;
      got = {clk_out, tick};
      e   = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL post_reset k=%0d got=%b exp=%b", k, got, e);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_glitch_free();
    test_disable();
    test_sync_clr();
    test_div_zero();
    test_async_reset();
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
